// File: rtl/memref_cmp_pkg.sv
// Shared types and constants for the memref write-port result checker.
package memref_cmp_pkg;

    // Width of the free-running capture cycle counter and per-stream cycle stamps.
    localparam int CYC_W = 32;

    // Checker phases: collect both write streams, walk the arrays, then hold the result.
    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/memref_shadow.sv
// Shadow copy of one memref write stream: data array, per-address seen bitmap,
// all-seen detection (including this cycle's write) and a combinational read port.
module memref_shadow #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 8,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,    // already qualified: valid address, capture phase
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              all_seen_o, // every address written, counting this cycle's write
    output logic              rewrite_o   // this cycle's write hits an address already written
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [SIZE-1:0]  seen_q;
    logic [SIZE-1:0]  seen_d;

    // Seen bitmap after this cycle's write, used both as next state and for all-seen.
    always_comb begin
        seen_d = seen_q;
        if (wr_en_i) begin
            seen_d[wr_addr_i] = 1'b1;
        end
    end

    // Seen bitmap is cleared by reset; the data array deliberately is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end

    // Data array: last write to an address wins.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_addr_i];
    assign all_seen_o = &seen_d;
    assign rewrite_o  = wr_en_i & seen_q[wr_addr_i];

endmodule

// File: rtl/memref_wr_compare.sv
// Result checker comparing two memref write streams (A: MLIR kernel, B: HLS kernel).
// Both streams are captured into shadow arrays; once every address has been written by
// both, the arrays are compared one element per cycle and a sticky result is reported.
// The write ports are plain strobes with no back-pressure: a strobe is taken in the cycle
// it is high, and there is no ready signal.
module memref_wr_compare
    import memref_cmp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 8,
    parameter int ADDR_W  = $clog2(SIZE),
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_wr_en,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wr_data,
    input  logic              b_wr_en,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wr_data,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic [ADDR_W-1:0] first_mismatch_addr,
    output logic [CYC_W-1:0]  a_cycles,
    output logic [CYC_W-1:0]  b_cycles,
    output logic              timeout,
    output logic              rewrite_err,
    output logic              late_wr,
    output logic              addr_err,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SIZE - 1);
    localparam logic [CYC_W-1:0]  TO_LAST   = CYC_W'(TIMEOUT - 1);

    cmp_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   mcnt_q, mcnt_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              rewrite_q, rewrite_d;
    logic              late_q, late_d;
    logic              addr_err_q, addr_err_d;
    logic [CYC_W-1:0]  a_cyc_q, a_cyc_d;
    logic [CYC_W-1:0]  b_cyc_q, b_cyc_d;

    logic              a_ok, b_ok;
    logic              in_capture;
    logic              a_we, b_we;
    logic [WIDTH-1:0]  a_rd, b_rd;
    logic              a_all, b_all;
    logic              a_rewrite, b_rewrite;

    // Address range check; with a power-of-two SIZE every address is legal.
    generate
        if (SIZE == (1 << ADDR_W)) begin : g_full_range
            assign a_ok = 1'b1;
            assign b_ok = 1'b1;
        end else begin : g_partial_range
            assign a_ok = (int'(a_addr) < SIZE);
            assign b_ok = (int'(b_addr) < SIZE);
        end
    endgenerate

    assign in_capture = (state_q == CAPTURE);
    assign a_we       = in_capture & a_wr_en & a_ok;
    assign b_we       = in_capture & b_wr_en & b_ok;

    memref_shadow #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) u_shadow_a (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (a_we),
        .wr_addr_i  (a_addr),
        .wr_data_i  (a_wr_data),
        .rd_addr_i  (idx_q),
        .rd_data_o  (a_rd),
        .all_seen_o (a_all),
        .rewrite_o  (a_rewrite)
    );

    memref_shadow #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) u_shadow_b (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (b_we),
        .wr_addr_i  (b_addr),
        .wr_data_i  (b_wr_data),
        .rd_addr_i  (idx_q),
        .rd_data_o  (b_rd),
        .all_seen_o (b_all),
        .rewrite_o  (b_rewrite)
    );

    // Next-state and result logic for the CAPTURE -> COMPARE -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        cyc_d      = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
        idx_d      = idx_q;
        mcnt_d     = mcnt_q;
        first_d    = first_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        rewrite_d  = rewrite_q;
        late_d     = late_q;
        addr_err_d = addr_err_q;
        a_cyc_d    = a_cyc_q;
        b_cyc_d    = b_cyc_q;

        case (state_q)
            CAPTURE: begin
                if (a_we) begin
                    a_cyc_d = cyc_q;
                end
                if (b_we) begin
                    b_cyc_d = cyc_q;
                end
                if (a_rewrite || b_rewrite) begin
                    rewrite_d = 1'b1;
                end
                if ((a_wr_en && !a_ok) || (b_wr_en && !b_ok)) begin
                    addr_err_d = 1'b1;
                end
                // Completion takes priority over a timeout in the same cycle.
                if (a_all && b_all) begin
                    state_d = COMPARE;
                    idx_d   = '0;
                end else if (cyc_q == TO_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
            COMPARE: begin
                if (a_wr_en || b_wr_en) begin
                    late_d = 1'b1;
                end
                if (a_rd != b_rd) begin
                    mcnt_d = mcnt_q + (ADDR_W + 1)'(1);
                    if (mcnt_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                if (a_wr_en || b_wr_en) begin
                    late_d = 1'b1;
                end
            end
        endcase
    end

    // State, counters and sticky result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAPTURE;
            cyc_q      <= '0;
            idx_q      <= '0;
            mcnt_q     <= '0;
            first_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rewrite_q  <= 1'b0;
            late_q     <= 1'b0;
            addr_err_q <= 1'b0;
            a_cyc_q    <= '0;
            b_cyc_q    <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            mcnt_q     <= mcnt_d;
            first_q    <= first_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            rewrite_q  <= rewrite_d;
            late_q     <= late_d;
            addr_err_q <= addr_err_d;
            a_cyc_q    <= a_cyc_d;
            b_cyc_q    <= b_cyc_d;
        end
    end

    assign done                = done_q;
    assign pass                = done_q & (mcnt_q == '0) & ~timeout_q;
    assign mismatch_cnt        = mcnt_q;
    assign first_mismatch_addr = first_q;
    assign a_cycles            = a_cyc_q;
    assign b_cycles            = b_cyc_q;
    assign timeout             = timeout_q;
    assign rewrite_err         = rewrite_q;
    assign late_wr             = late_q;
    assign addr_err            = addr_err_q;
    assign dbg_state           = state_q;

endmodule
